// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encoding, register offsets, STATUS bit positions and the BAUDDIV merge.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Word offsets inside the 16-byte window (address bits [3:2]).
    localparam logic [1:0] TXDATA_OFS  = 2'd0;
    localparam logic [1:0] STATUS_OFS  = 2'd1;
    localparam logic [1:0] BAUDDIV_OFS = 2'd2;

    // STATUS register bit positions.
    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;

    // Byte-lane merge of a BAUDDIV store; a zero divisor would stall the
    // bit timer, so it is forced to 1.
    function automatic logic [15:0] baud_merge(input logic [15:0] cur,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  be);
        logic [15:0] v;
        v = cur;
        if (be[0]) v[7:0]  = wdata[7:0];
        if (be[1]) v[15:8] = wdata[15:8];
        if (v == 16'd0) v = 16'd1;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. No write-to-read bypass: an
// entry pushed on one edge becomes visible on o_dout after that edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with different wrap bit means the writer is a lap ahead.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Pointer update; reset flushes all queued entries.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents need no reset since the pointers gate them.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-responder UART transmitter: address decode, TXDATA/STATUS/BAUDDIV
// registers, registered read mux and an 8N1 serializer fed by a FIFO.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int                DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] BASE_ADDR    = 32'h0001_0000,
    parameter int                FIFO_DEPTH   = 4,
    parameter logic [15:0]       BAUD_DIV_RST = 16'd868
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic [DWIDTH-1:0] Mem_Data_Address,
    input  logic [DWIDTH-1:0] Mem_Data_Write,
    input  logic [3:0]        Write_Ctrl,
    input  logic              Read_Ctrl,
    output logic [DWIDTH-1:0] Mem_Data_Read,
    output logic              Uart_Tx,
    output logic              Tx_Irq
);
    // Registers
    tx_state_t         r_state;
    logic              r_tx;
    logic [15:0]       r_cnt;
    logic [15:0]       r_div_lat;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [15:0]       r_baud;
    logic              r_ovf;
    logic [DWIDTH-1:0] r_rdata;

    // Wires
    logic              w_sel;
    logic [1:0]        w_ofs;
    logic              w_wr;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_ovf_clr;
    logic              w_baud_wr;
    logic              w_full;
    logic              w_empty;
    logic              w_busy;
    logic [7:0]        w_fifo_dout;
    logic [2:0]        w_next_idx;
    logic [DWIDTH-1:0] w_rd_mux;
    logic              w_unused;

    // Window decode; byte offset bits and upper store lanes carry no meaning here.
    assign w_sel     = (Mem_Data_Address[DWIDTH-1:4] == BASE_ADDR[DWIDTH-1:4]);
    assign w_ofs     = Mem_Data_Address[3:2];
    assign w_wr      = w_sel && (Write_Ctrl != 4'd0);
    assign w_push    = w_wr && (w_ofs == TXDATA_OFS) && Write_Ctrl[0];
    assign w_ovf_set = w_push && w_full;
    assign w_ovf_clr = w_wr && (w_ofs == STATUS_OFS) && Write_Ctrl[0] &&
                       Mem_Data_Write[ST_OVF_BIT];
    assign w_baud_wr = w_wr && (w_ofs == BAUDDIV_OFS);
    assign w_busy    = (r_state != IDLE);
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_next_idx = r_bit_idx + 3'd1;
    assign w_unused  = &{1'b0, Mem_Data_Address[1:0],
                         Mem_Data_Write[DWIDTH-1:16], Write_Ctrl[3:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Clk_Core),
        .i_rst_n (Rst_Core_N),
        .i_push  (w_push),
        .i_din   (Mem_Data_Write[7:0]),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_dout  (w_fifo_dout)
    );

    // Read mux over the current register state.
    always_comb begin
        w_rd_mux = '0;
        case (w_ofs)
            STATUS_OFS: begin
                w_rd_mux[ST_FULL_BIT]  = w_full;
                w_rd_mux[ST_EMPTY_BIT] = w_empty;
                w_rd_mux[ST_BUSY_BIT]  = w_busy;
                w_rd_mux[ST_OVF_BIT]   = r_ovf;
            end
            BAUDDIV_OFS: w_rd_mux[15:0] = r_baud;
            default:     w_rd_mux = '0;
        endcase
    end

    // Registered load data; zero whenever no selected load was sampled.
    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            r_rdata <= '0;
        end else if (Read_Ctrl && w_sel) begin
            r_rdata <= w_rd_mux;
        end else begin
            r_rdata <= '0;
        end
    end

    // Sticky overflow flag; a same-cycle set beats the W1C clear.
    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Baud divisor register with per-lane byte enables.
    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            r_baud <= BAUD_DIV_RST;
        end else if (w_baud_wr) begin
            r_baud <= baud_merge(r_baud, Mem_Data_Write[15:0], Write_Ctrl[1:0]);
        end
    end

    // 8N1 serializer; divisor latched at frame start so mid-frame writes
    // only affect the following frame.
    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_cnt     <= '0;
            r_div_lat <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_shift   <= w_fifo_dout;
                        r_div_lat <= r_baud;
                        r_cnt     <= r_baud - 16'd1;
                    end
                end
                default: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_cnt <= r_div_lat - 16'd1;
                        case (r_state)
                            START: begin
                                r_state   <= DATA;
                                r_bit_idx <= 3'd0;
                                r_tx      <= r_shift[0];
                            end
                            DATA: begin
                                if (r_bit_idx == 3'd7) begin
                                    r_state <= STOP;
                                    r_tx    <= 1'b1;
                                end else begin
                                    r_bit_idx <= w_next_idx;
                                    r_tx      <= r_shift[w_next_idx];
                                end
                            end
                            default: begin
                                r_state <= IDLE;
                                r_tx    <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign Mem_Data_Read = r_rdata;
    assign Uart_Tx       = r_tx;
    assign Tx_Irq        = w_empty && (r_state == IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO
// overflow, divisor latching, window decode and mid-frame reset.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_BD = BASE + 32'h8;
    localparam logic [31:0] A_R3 = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wctrl;
    logic        rctrl;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        tx_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_uart_tx dut (
        .Clk_Core         (clk),
        .Rst_Core_N       (rst_n),
        .Mem_Data_Address (addr),
        .Mem_Data_Write   (wdata),
        .Write_Ctrl       (wctrl),
        .Read_Ctrl        (rctrl),
        .Mem_Data_Read    (rdata),
        .Uart_Tx          (uart_tx),
        .Tx_Irq           (tx_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr  = a;
        wdata = d;
        wctrl = be;
        tick();
        wctrl = 4'd0;
        $display("store addr=%h data=%h be=%b", a, d, be);
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        rctrl = 1'b1;
        tick();
        d     = rdata;
        rctrl = 1'b0;
        $display("load  addr=%h data=%h", a, d);
    endtask

    // Waits (bounded) for the line to go low, then counts low samples.
    task automatic low_run(input int bound, output int waited, output int len);
        waited = 0;
        len    = 0;
        while (uart_tx !== 1'b0 && waited < bound) begin
            tick();
            waited++;
        end
        while (uart_tx === 1'b0 && len < bound) begin
            tick();
            len++;
        end
    endtask

    // Frame decoder for divisor 2: records start cycle and received byte.
    bit         mon_en = 1'b0;
    int         mon_frames = 0;
    int         mon_c = -1;
    int         mon_cycle = 0;
    int         mon_start [8];
    logic [7:0] mon_byte [8];
    logic [7:0] mon_sh = 8'h00;

    always @(negedge clk) begin
        mon_cycle++;
        if (mon_en) begin
            if (mon_c < 0) begin
                if (uart_tx === 1'b0) begin
                    if (mon_frames < 8) mon_start[mon_frames] = mon_cycle;
                    mon_c = 0;
                end
            end else begin
                mon_c++;
                if (mon_c >= 2 && mon_c <= 16 && (mon_c % 2) == 0)
                    mon_sh = {uart_tx, mon_sh[7:1]};
                if (mon_c == 19) begin
                    if (mon_frames < 8) mon_byte[mon_frames] = mon_sh;
                    $display("frame %0d byte=%h start_cycle=%0d", mon_frames, mon_sh, mon_start[mon_frames]);
                    mon_frames++;
                    mon_c = -1;
                end
            end
        end
    end

    logic [31:0] st;
    logic [7:0]  byte_v;
    logic        exp_bit;
    logic [7:0]  exp_bytes [5];
    int          w;
    int          len;
    int          lows;

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        wctrl = 4'd0;
        rctrl = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_irq", {31'd0, tx_irq}, 32'd1);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        load(A_ST, st);
        check("rst_status", st, 32'h2);
        load(A_BD, st);
        check("rst_bauddiv", st, 32'd868);
        tick();
        check("rdata_idle_zero", rdata, 32'd0);

        // Single frame 0xA5 at divisor 4
        store(A_BD, 32'd4, 4'b0011);
        store(A_TX, 32'hA5, 4'b0001);
        check("a5_tx_before_start", {31'd0, uart_tx}, 32'd1);
        check("a5_irq_busy", {31'd0, tx_irq}, 32'd0);
        tick();
        byte_v = 8'hA5;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       exp_bit = 1'b0;
            else if (i < 36) exp_bit = byte_v[(i - 4) / 4];
            else             exp_bit = 1'b1;
            check($sformatf("a5_bit_cycle%0d", i), {31'd0, uart_tx}, {31'd0, exp_bit});
            tick();
        end
        check("a5_irq_after", {31'd0, tx_irq}, 32'd1);
        check("a5_tx_idle", {31'd0, uart_tx}, 32'd1);

        // Six back-to-back stores at divisor 2: one popped, four queued, one dropped
        store(A_BD, 32'd2, 4'b0011);
        tick();
        mon_en = 1'b1;
        store(A_TX, 32'h11, 4'b0001);
        store(A_TX, 32'h22, 4'b0001);
        store(A_TX, 32'h33, 4'b0001);
        store(A_TX, 32'h44, 4'b0001);
        store(A_TX, 32'h55, 4'b0001);
        store(A_TX, 32'h66, 4'b0001);
        load(A_ST, st);
        check("ovf_full_and_ovf", st & 32'h9, 32'h9);
        check("ovf_busy", {31'd0, st[2]}, 32'd1);
        store(A_ST, 32'h8, 4'b0001);
        load(A_ST, st);
        check("ovf_w1c", st, 32'h5);
        w = 0;
        while (tx_irq !== 1'b1 && w < 500) begin
            tick();
            w++;
        end
        check("ovf_drain_in_time", {31'd0, (w < 500)}, 32'd1);
        repeat (4) tick();
        mon_en = 1'b0;
        exp_bytes[0] = 8'h11;
        exp_bytes[1] = 8'h22;
        exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h44;
        exp_bytes[4] = 8'h55;
        check("ovf_frame_count", mon_frames, 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("ovf_byte%0d", k), {24'd0, mon_byte[k]}, {24'd0, exp_bytes[k]});
            if (k > 0)
                check($sformatf("ovf_gap%0d", k), mon_start[k] - mon_start[k-1], 32'd21);
        end

        // Divisor zero clamp and single-lane write
        store(A_BD, 32'd0, 4'b0011);
        load(A_BD, st);
        check("baud_zero_clamp", st, 32'd1);
        store(A_BD, 32'h0000_0200, 4'b0010);
        load(A_BD, st);
        check("baud_lane1", st, 32'h201);

        // Divisor change mid-frame: 0xFF frames, start bit length shows divisor
        store(A_BD, 32'd3, 4'b0011);
        store(A_TX, 32'hFF, 4'b0001);
        store(A_TX, 32'hFF, 4'b0001);
        low_run(200, w, len);
        check("div3_start_len", len, 32'd3);
        store(A_BD, 32'd5, 4'b0011);
        low_run(200, w, len);
        check("div3_high_span", w, 32'd27);
        check("div5_start_len", len, 32'd5);
        w = 0;
        while (tx_irq !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        check("div5_drain_in_time", {31'd0, (w < 200)}, 32'd1);

        // Window decode
        load(A_BD, st);
        check("dec_bauddiv", st, 32'd5);
        load(BASE + 32'h10, st);
        check("dec_outside_read", st, 32'd0);
        load(A_BD, st);
        load(A_R3, st);
        check("dec_ofs3_read", st, 32'd0);
        load(A_BD, st);
        load(A_TX, st);
        check("dec_txdata_read", st, 32'd0);
        store(BASE + 32'h10, 32'h55, 4'b1111);
        store(32'h0000_0000, 32'h55, 4'b1111);
        load(A_ST, st);
        check("dec_outside_store", st, 32'h2);
        check("dec_irq_idle", {31'd0, tx_irq}, 32'd1);

        // Reset during DATA with two bytes queued
        store(A_TX, 32'hA1, 4'b0001);
        store(A_TX, 32'hB2, 4'b0001);
        store(A_TX, 32'hC3, 4'b0001);
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        check("mrst_tx", {31'd0, uart_tx}, 32'd1);
        check("mrst_irq", {31'd0, tx_irq}, 32'd1);
        rst_n = 1'b1;
        load(A_ST, st);
        check("mrst_status", st, 32'h2);
        load(A_BD, st);
        check("mrst_bauddiv", st, 32'd868);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            if (uart_tx !== 1'b1) lows++;
            tick();
        end
        check("mrst_no_frames", lows, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
